// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the two-requester SRAM arbiter.
package sram_arb_pkg;

    localparam int SRAM_ARB_DATA_W = 32;
    localparam int SRAM_ARB_ADDR_W = 32;

    typedef enum logic [0:0] {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic [0:0] {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_owner_e;

endpackage

// File: rtl/sram_arb_if.sv
// SRAM channel bundle: the arbiter drives it through the master modport, the SRAM through slave.
interface sram_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    sram_rd_en;
    logic [ADDR_WIDTH-1:0]   sram_rd_addr;
    logic                    sram_rd_valid;
    logic [DATA_WIDTH-1:0]   sram_rd_data;
    logic                    sram_wr_en;
    logic [ADDR_WIDTH-1:0]   sram_wr_addr;
    logic [DATA_WIDTH-1:0]   sram_wr_data;
    logic [DATA_WIDTH/8-1:0] sram_wr_mask;

    modport master (
        output sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_mask,
        input  sram_rd_valid, sram_rd_data
    );

    modport slave (
        input  sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data, sram_wr_mask,
        output sram_rd_valid, sram_rd_data
    );
endinterface

// File: rtl/sram_arb_rr.sv
// Two-way round-robin picker; ptr_q=0 favours M0 on contention, flips to the loser on each grant.
module sram_arb_rr (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       upd,
    output logic [1:0] gnt
);
    logic ptr_q, ptr_d;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
        end
        ptr_d = ptr_q;
        if (upd) begin
            ptr_d = gnt[0];
        end
        if (!rst_n) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        ptr_q <= ptr_d;
    end
endmodule

// File: rtl/sram_arb.sv
// Shares one SRAM channel between fetch (M0) and load/store (M1); one outstanding read.
// Define SRAM_ARB_TIMEOUT_EN to bound the read wait and add the mN_rerr outputs.
module sram_arb
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = SRAM_ARB_DATA_W,
    parameter int ADDR_WIDTH = SRAM_ARB_ADDR_W,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_req,
    input  logic                    m0_we,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wmask,
    output logic                    m0_gnt,
    output logic                    m0_rvalid,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
`ifdef SRAM_ARB_TIMEOUT_EN
    output logic                    m0_rerr,
    output logic                    m1_rerr,
`endif
    input  logic                    m1_req,
    input  logic                    m1_we,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wmask,
    output logic                    m1_gnt,
    output logic                    m1_rvalid,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    sram_arb_if.master              sram
);
    arb_state_e state_q, state_d;
    arb_owner_e owner_q, owner_d;
    logic [1:0] req_vec, rr_gnt;
    logic       rsp_vld;
    logic       wr_en, rd_en;
    logic [ADDR_WIDTH-1:0]   wr_addr, rd_addr;
    logic [DATA_WIDTH-1:0]   wr_data, rd_data;
    logic [DATA_WIDTH/8-1:0] wr_mask;

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rsp_err;
`endif

    // Requests only compete in IDLE and out of reset; grants fall straight out of the picker.
    assign req_vec = {m1_req, m0_req} & {2{rst_n && (state_q == ARB_IDLE)}};

    sram_arb_rr u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_vec),
        .upd   (|rr_gnt),
        .gnt   (rr_gnt)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rsp_vld = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        wr_mask = '0;
        rd_addr = '0;
`ifdef SRAM_ARB_TIMEOUT_EN
        rsp_err = 1'b0;
        cnt_d   = cnt_q + 1'b1;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (|rr_gnt) begin
                    if (rr_gnt[1] ? m1_we : m0_we) begin
                        wr_en   = 1'b1;
                        wr_addr = rr_gnt[1] ? m1_addr  : m0_addr;
                        wr_data = rr_gnt[1] ? m1_wdata : m0_wdata;
                        wr_mask = rr_gnt[1] ? m1_wmask : m0_wmask;
                    end else begin
                        rd_en   = 1'b1;
                        rd_addr = rr_gnt[1] ? m1_addr : m0_addr;
                        state_d = ARB_RD_WAIT;
                        owner_d = rr_gnt[1] ? ARB_M1 : ARB_M0;
`ifdef SRAM_ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ARB_RD_WAIT: begin
                if (sram.sram_rd_valid) begin
                    rsp_vld = 1'b1;
                    state_d = ARB_IDLE;
                end
`ifdef SRAM_ARB_TIMEOUT_EN
                else if (cnt_d == TO_VAL) begin
                    rsp_vld = 1'b1;
                    rsp_err = 1'b1;
                    state_d = ARB_IDLE;
                end
`endif
            end
            default: state_d = ARB_IDLE;
        endcase
        // Reset drops any outstanding read so a late return is never delivered.
        if (!rst_n) begin
            state_d = ARB_IDLE;
            owner_d = ARB_M0;
            rsp_vld = 1'b0;
`ifdef SRAM_ARB_TIMEOUT_EN
            rsp_err = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        owner_q <= owner_d;
`ifdef SRAM_ARB_TIMEOUT_EN
        cnt_q   <= cnt_d;
`endif
    end

`ifdef SRAM_ARB_TIMEOUT_EN
    assign rd_data = rsp_err ? '0 : sram.sram_rd_data;
    assign m0_rerr = rsp_err && (owner_q == ARB_M0);
    assign m1_rerr = rsp_err && (owner_q == ARB_M1);
`else
    assign rd_data = sram.sram_rd_data;
`endif

    assign m0_gnt    = rr_gnt[0];
    assign m1_gnt    = rr_gnt[1];
    assign m0_rvalid = rsp_vld && (owner_q == ARB_M0);
    assign m1_rvalid = rsp_vld && (owner_q == ARB_M1);
    assign m0_rdata  = rd_data;
    assign m1_rdata  = rd_data;

    assign sram.sram_rd_en   = rd_en;
    assign sram.sram_rd_addr = rd_addr;
    assign sram.sram_wr_en   = wr_en;
    assign sram.sram_wr_addr = wr_addr;
    assign sram.sram_wr_data = wr_data;
    assign sram.sram_wr_mask = wr_mask;
endmodule

// File: tb/tb_sram_arb.sv
// Directed bench for sram_arb; covers the timeout path when SRAM_ARB_TIMEOUT_EN is defined.
module tb_sram_arb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wmask, m1_wmask;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
`ifdef SRAM_ARB_TIMEOUT_EN
    logic        m0_rerr, m1_rerr;
`endif
    int n_cmp = 0;
    int n_err = 0;

    sram_arb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) sram_bus ();

    sram_arb #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
`ifdef SRAM_ARB_TIMEOUT_EN
        .TIMEOUT    (4)
`else
        .TIMEOUT    (255)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wmask  (m0_wmask),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
`ifdef SRAM_ARB_TIMEOUT_EN
        .m0_rerr   (m0_rerr),
        .m1_rerr   (m1_rerr),
`endif
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wmask  (m1_wmask),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .sram      (sram_bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: inputs change just after the falling edge, checks follow 1 ns later.
    task automatic next_cyc();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wmask = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wmask = '0;
        sram_bus.sram_rd_valid = 1'b0;
        sram_bus.sram_rd_data  = '0;

        // Reset held with both requesters asking to write
        next_cyc();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hAA; m0_wmask = 4'hF;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'hBB; m1_wmask = 4'h3;
        #1;
        chk("rst_m0_gnt", m0_gnt, 0);
        chk("rst_m1_gnt", m1_gnt, 0);
        chk("rst_wr_en", sram_bus.sram_wr_en, 0);
        chk("rst_rd_en", sram_bus.sram_rd_en, 0);
        chk("rst_wr_addr", sram_bus.sram_wr_addr, 0);
        chk("rst_rvalid", {m1_rvalid, m0_rvalid}, 0);

        // Contended writes: M0 first after reset, then M1
        next_cyc();
        rst_n = 1'b1;
        #1;
        chk("w0_m0_gnt", m0_gnt, 1);
        chk("w0_m1_gnt", m1_gnt, 0);
        chk("w0_wr_en", sram_bus.sram_wr_en, 1);
        chk("w0_wr_addr", sram_bus.sram_wr_addr, 32'h10);
        chk("w0_wr_data", sram_bus.sram_wr_data, 32'hAA);
        chk("w0_wr_mask", sram_bus.sram_wr_mask, 4'hF);
        next_cyc();
        #1;
        chk("w1_m1_gnt", m1_gnt, 1);
        chk("w1_m0_gnt", m0_gnt, 0);
        chk("w1_wr_addr", sram_bus.sram_wr_addr, 32'h20);
        chk("w1_wr_data", sram_bus.sram_wr_data, 32'hBB);
        chk("w1_wr_mask", sram_bus.sram_wr_mask, 4'h3);

        // Stray read return while idle
        next_cyc();
        m0_req = 1'b0; m1_req = 1'b0;
        sram_bus.sram_rd_valid = 1'b1; sram_bus.sram_rd_data = 32'h55;
        #1;
        chk("stray_rvalid", {m1_rvalid, m0_rvalid}, 0);
        chk("stray_rdata_pass", m0_rdata, 32'h55);
        chk("idle_rd_en", sram_bus.sram_rd_en, 0);

        // M1 read of 0x40, returned three cycles later; M0 queued behind it
        next_cyc();
        sram_bus.sram_rd_valid = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h40;
        #1;
        chk("r1_m1_gnt", m1_gnt, 1);
        chk("r1_rd_en", sram_bus.sram_rd_en, 1);
        chk("r1_rd_addr", sram_bus.sram_rd_addr, 32'h40);
        chk("r1_wr_en", sram_bus.sram_wr_en, 0);
        next_cyc();
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h80;
        #1;
        chk("wait1_m0_gnt", m0_gnt, 0);
        chk("wait1_rd_en", sram_bus.sram_rd_en, 0);
        next_cyc();
        #1;
        chk("wait2_m0_gnt", m0_gnt, 0);
        chk("wait2_rvalid", {m1_rvalid, m0_rvalid}, 0);
        next_cyc();
        sram_bus.sram_rd_valid = 1'b1; sram_bus.sram_rd_data = 32'h1234;
        #1;
        chk("ret_m1_rvalid", m1_rvalid, 1);
        chk("ret_m1_rdata", m1_rdata, 32'h1234);
        chk("ret_m0_rvalid", m0_rvalid, 0);
        chk("ret_m0_gnt", m0_gnt, 0);
        next_cyc();
        sram_bus.sram_rd_valid = 1'b0;
        #1;
        chk("after_m0_gnt", m0_gnt, 1);
        chk("after_rd_addr", sram_bus.sram_rd_addr, 32'h80);
        chk("after_m1_rvalid", m1_rvalid, 0);

        // Reset pulse during the M0 read, then a late return plus a fresh M1 write
        next_cyc();
        m0_req = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstw_m0_gnt", m0_gnt, 0);
        next_cyc();
        rst_n = 1'b1;
        sram_bus.sram_rd_valid = 1'b1; sram_bus.sram_rd_data = 32'h77;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h30; m1_wdata = 32'hCC;
        #1;
        chk("late_rvalid", {m1_rvalid, m0_rvalid}, 0);
        chk("late_m1_gnt", m1_gnt, 1);
        chk("late_wr_addr", sram_bus.sram_wr_addr, 32'h30);

        // M0 read with 1-cycle SRAM; M1 write waits for the next idle cycle
        next_cyc();
        sram_bus.sram_rd_valid = 1'b0;
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
        #1;
        chk("c0_m0_gnt", m0_gnt, 1);
        chk("c0_rd_en", sram_bus.sram_rd_en, 1);
        next_cyc();
        m0_addr = 32'h104;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h44; m1_wdata = 32'hDD;
        sram_bus.sram_rd_valid = 1'b1; sram_bus.sram_rd_data = 32'hABCD;
        #1;
        chk("c1_m0_rvalid", m0_rvalid, 1);
        chk("c1_m0_rdata", m0_rdata, 32'hABCD);
        chk("c1_gnt", {m1_gnt, m0_gnt}, 0);
        next_cyc();
        sram_bus.sram_rd_valid = 1'b0;
        #1;
        chk("c2_m1_gnt", m1_gnt, 1);
        chk("c2_m0_gnt", m0_gnt, 0);
        chk("c2_wr_addr", sram_bus.sram_wr_addr, 32'h44);
        chk("c2_rd_en", sram_bus.sram_rd_en, 0);
        next_cyc();
        m1_req = 1'b0;
        #1;
        chk("c3_m0_gnt", m0_gnt, 1);
        chk("c3_rd_addr", sram_bus.sram_rd_addr, 32'h104);

`ifdef SRAM_ARB_TIMEOUT_EN
        // SRAM never answers: error response four cycles after issue
        next_cyc();
        m0_req = 1'b0;
        sram_bus.sram_rd_data = 32'h9999;
        #1;
        chk("to1_m0_rvalid", m0_rvalid, 0);
        next_cyc();
        #1;
        chk("to2_m0_rvalid", m0_rvalid, 0);
        next_cyc();
        #1;
        chk("to3_m0_rvalid", m0_rvalid, 0);
        chk("to3_m0_rerr", m0_rerr, 0);
        next_cyc();
        #1;
        chk("to4_m0_rvalid", m0_rvalid, 1);
        chk("to4_m0_rerr", m0_rerr, 1);
        chk("to4_m0_rdata", m0_rdata, 0);
        chk("to4_m1_rvalid", m1_rvalid, 0);
        next_cyc();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h60;
        #1;
        chk("to5_m1_gnt", m1_gnt, 1);
        chk("to5_m0_rerr", m0_rerr, 0);
`else
        // Default build: the read completes whenever the SRAM answers
        next_cyc();
        m0_req = 1'b0;
        #1;
        chk("nr1_m0_rvalid", m0_rvalid, 0);
        next_cyc();
        sram_bus.sram_rd_valid = 1'b1; sram_bus.sram_rd_data = 32'h5A5A;
        #1;
        chk("nr2_m0_rvalid", m0_rvalid, 1);
        chk("nr2_m0_rdata", m0_rdata, 32'h5A5A);
        next_cyc();
        sram_bus.sram_rd_valid = 1'b0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h60;
        #1;
        chk("nr3_m1_gnt", m1_gnt, 1);
`endif

        next_cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
